// File: rtl/vc_link_scheduler.sv
// rtl/vc_link_scheduler.sv - round-robin, credit-gated scheduler sharing one output link among VC buffers
module vc_link_scheduler #(
    parameter int NUM_VC  = 4,
    parameter int VC_W    = 2,
    parameter int DSIZE   = 32,
    parameter int CREDITS = 32,
    parameter int CW      = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_VC-1:0]       vc_empty,
    input  logic [NUM_VC*DSIZE-1:0] vc_data_out,
    output logic [NUM_VC-1:0]       vc_read_en,
    input  logic [NUM_VC-1:0]       credit_in,
    output logic                    link_valid,
    output logic [VC_W-1:0]         link_vc,
    output logic [DSIZE-1:0]        link_data,
    output logic                    credit_err,
    output logic                    busy
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [CW-1:0]     r_credit [NUM_VC];
    logic [VC_W-1:0]   r_rr_ptr;
    logic              r_s1_valid;
    logic [VC_W-1:0]   r_s1_vc;
    logic              r_link_valid;
    logic [VC_W-1:0]   r_link_vc;
    logic [DSIZE-1:0]  r_link_data;
    logic              r_credit_err;
    logic              r_busy;

    logic [NUM_VC-1:0] w_elig;
    logic              w_grant_valid;
    logic [VC_W-1:0]   w_grant_id;
    logic [NUM_VC-1:0] w_read_en;
    logic [CW-1:0]     w_credit_nxt [NUM_VC];
    logic              w_overflow;
    logic [DSIZE-1:0]  w_s1_data;
    logic [VC_W-1:0]   w_rr_nxt;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_elig[i] = !vc_empty[i] && (r_credit[i] != '0);
        end
    end

    // Two passes give the wrapped scan: first VCs at or above rr_ptr, then the rest from 0.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!w_grant_valid && w_elig[i] && (VC_W'(i) >= r_rr_ptr)) begin
                w_grant_valid = 1'b1;
                w_grant_id    = VC_W'(i);
            end
        end
        for (int i = 0; i < NUM_VC; i++) begin
            if (!w_grant_valid && w_elig[i]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = VC_W'(i);
            end
        end
    end

    always_comb begin
        w_read_en = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_read_en[i] = w_grant_valid && (w_grant_id == VC_W'(i));
        end
    end

    assign vc_read_en = reset ? '0 : w_read_en;
    assign w_rr_nxt   = (w_grant_id == VC_W'(NUM_VC - 1)) ? '0 : w_grant_id + VC_W'(1);

    // A grant and a returned credit in the same cycle cancel out.
    always_comb begin
        w_overflow = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_credit_nxt[i] = r_credit[i];
            if (w_read_en[i] && !credit_in[i]) begin
                w_credit_nxt[i] = r_credit[i] - CW'(1);
            end else if (credit_in[i] && !w_read_en[i]) begin
                if (r_credit[i] == CRED_MAX) begin
                    w_overflow = 1'b1;
                end else begin
                    w_credit_nxt[i] = r_credit[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_s1_data = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (r_s1_vc == VC_W'(i)) begin
                w_s1_data = vc_data_out[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_credit[i] <= CRED_MAX;
            end
            r_rr_ptr     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_vc      <= '0;
            r_link_valid <= 1'b0;
            r_link_vc    <= '0;
            r_link_data  <= '0;
            r_credit_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
            if (w_grant_valid) begin
                r_rr_ptr <= w_rr_nxt;
                r_s1_vc  <= w_grant_id;
            end
            r_s1_valid   <= w_grant_valid;
            r_link_valid <= r_s1_valid;
            r_link_vc    <= r_s1_vc;
            r_link_data  <= w_s1_data;
            r_credit_err <= r_credit_err | w_overflow;
            r_busy       <= (|(~vc_empty)) | r_s1_valid | r_link_valid;
        end
    end

    assign link_valid = r_link_valid;
    assign link_vc    = r_link_vc;
    assign link_data  = r_link_data;
    assign credit_err = r_credit_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_vc_link_scheduler.sv
// tb/tb_vc_link_scheduler.sv - directed, table-driven bench for vc_link_scheduler
module tb_vc_link_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   vc_empty;
    logic [127:0] vc_data_out;
    logic [3:0]   vc_read_en;
    logic [3:0]   credit_in = '0;
    logic         link_valid;
    logic [1:0]   link_vc;
    logic [31:0]  link_data;
    logic         credit_err;
    logic         busy;

    logic [3:0]   vc_empty2 = 4'b1111;
    logic [127:0] vc_data_out2 = {32'h0, 32'h0, 32'h5A5A0001, 32'h0};
    logic [3:0]   vc_read_en2;
    logic [3:0]   credit_in2 = '0;
    logic         link_valid2;
    logic [1:0]   link_vc2;
    logic [31:0]  link_data2;
    logic         credit_err2;
    logic         busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vc_link_scheduler u_dut (
        .clk(clk), .reset(reset), .vc_empty(vc_empty), .vc_data_out(vc_data_out),
        .vc_read_en(vc_read_en), .credit_in(credit_in), .link_valid(link_valid),
        .link_vc(link_vc), .link_data(link_data), .credit_err(credit_err), .busy(busy)
    );

    vc_link_scheduler #(.CREDITS(2), .CW(2)) u_dut2 (
        .clk(clk), .reset(reset), .vc_empty(vc_empty2), .vc_data_out(vc_data_out2),
        .vc_read_en(vc_read_en2), .credit_in(credit_in2), .link_valid(link_valid2),
        .link_vc(link_vc2), .link_data(link_data2), .credit_err(credit_err2), .busy(busy2)
    );

    // VC buffer model with a registered data_out that takes the popped flit at the pop edge
    logic [31:0] mem [4][16];
    int          wr_ptr [4] = '{0, 0, 0, 0};
    int          rd_ptr [4] = '{0, 0, 0, 0};
    logic [31:0] dout [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= wr_ptr[i];
                dout[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vc_read_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
                    dout[i]   <= mem[i][rd_ptr[i] % 16];
                    rd_ptr[i] <= rd_ptr[i] + 1;
                end
            end
        end
    end

    always_comb begin
        vc_empty = '1;
        for (int i = 0; i < 4; i++) begin
            vc_empty[i] = (wr_ptr[i] == rd_ptr[i]);
        end
    end

    assign vc_data_out = {dout[3], dout[2], dout[1], dout[0]};

    task automatic push(input int v, input logic [31:0] d);
        mem[v][wr_ptr[v] % 16] = d;
        wr_ptr[v] = wr_ptr[v] + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  push;
        logic [3:0]  exp_rd;
        logic        exp_lv;
        logic [1:0]  exp_vc;
        logic [31:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t rr_tab [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rr_tab[0]  = '{4'hF, 4'b0001, 1'b0, 2'd0, 32'h0,        1'b0};
        rr_tab[1]  = '{4'hF, 4'b0010, 1'b0, 2'd0, 32'h0,        1'b1};
        rr_tab[2]  = '{4'hF, 4'b0100, 1'b1, 2'd0, 32'hA0000000, 1'b1};
        rr_tab[3]  = '{4'h0, 4'b1000, 1'b1, 2'd1, 32'hA0000010, 1'b1};
        rr_tab[4]  = '{4'h0, 4'b0001, 1'b1, 2'd2, 32'hA0000020, 1'b1};
        rr_tab[5]  = '{4'h0, 4'b0010, 1'b1, 2'd3, 32'hA0000030, 1'b1};
        rr_tab[6]  = '{4'h0, 4'b0100, 1'b1, 2'd0, 32'hA0000001, 1'b1};
        rr_tab[7]  = '{4'h0, 4'b1000, 1'b1, 2'd1, 32'hA0000011, 1'b1};
        rr_tab[8]  = '{4'h0, 4'b0001, 1'b1, 2'd2, 32'hA0000021, 1'b1};
        rr_tab[9]  = '{4'h0, 4'b0010, 1'b1, 2'd3, 32'hA0000031, 1'b1};
        rr_tab[10] = '{4'h0, 4'b0100, 1'b1, 2'd0, 32'hA0000002, 1'b1};
        rr_tab[11] = '{4'h0, 4'b1000, 1'b1, 2'd1, 32'hA0000012, 1'b1};
        rr_tab[12] = '{4'h0, 4'b0000, 1'b1, 2'd2, 32'hA0000022, 1'b1};
        rr_tab[13] = '{4'h0, 4'b0000, 1'b1, 2'd3, 32'hA0000032, 1'b1};
        rr_tab[14] = '{4'h0, 4'b0000, 1'b0, 2'd0, 32'h0,        1'b1};
        rr_tab[15] = '{4'h0, 4'b0000, 1'b0, 2'd0, 32'h0,        1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // idle after reset
        @(negedge clk); #1;
        check("idle_rd", 32'(vc_read_en), 32'h0);
        check("idle_lv", 32'(link_valid), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_err", 32'(credit_err), 32'h0);

        // single flit on VC2
        @(negedge clk);
        push(2, 32'h0101A5A5);
        #1;
        check("single_rd", 32'(vc_read_en), 32'h4);
        @(negedge clk); #1;
        check("single_lv_t1", 32'(link_valid), 32'h0);
        check("single_busy_t1", 32'(busy), 32'h1);
        @(negedge clk); #1;
        check("single_lv_t2", 32'(link_valid), 32'h1);
        check("single_vc", 32'(link_vc), 32'h2);
        check("single_data", link_data, 32'h0101A5A5);
        check("single_credit", 32'(u_dut.r_credit[2]), 32'd31);
        @(negedge clk); #1;
        check("single_lv_t3", 32'(link_valid), 32'h0);
        check("single_rr", 32'(u_dut.r_rr_ptr), 32'h3);

        // round robin over all four VCs, three flits each
        do_reset();
        for (int r = 0; r < 16; r++) begin
            for (int v = 0; v < 4; v++) begin
                if (rr_tab[r].push[v]) push(v, 32'hA0000000 | 32'(v << 4) | 32'(r));
            end
            #1;
            check($sformatf("rr%0d_rd", r), 32'(vc_read_en), 32'(rr_tab[r].exp_rd));
            check($sformatf("rr%0d_lv", r), 32'(link_valid), 32'(rr_tab[r].exp_lv));
            check($sformatf("rr%0d_busy", r), 32'(busy), 32'(rr_tab[r].exp_busy));
            if (rr_tab[r].exp_lv) begin
                check($sformatf("rr%0d_vc", r), 32'(link_vc), 32'(rr_tab[r].exp_vc));
                check($sformatf("rr%0d_data", r), link_data, rr_tab[r].exp_data);
            end
            @(negedge clk);
        end
        check("rr_ptr_end", 32'(u_dut.r_rr_ptr), 32'h0);
        check("rr_credit0", 32'(u_dut.r_credit[0]), 32'd29);
        check("rr_credit3", 32'(u_dut.r_credit[3]), 32'd29);

        // credit return in the same cycle as a grant
        push(0, 32'h00C0FFEE);
        credit_in = 4'b0001;
        #1;
        check("simul_rd", 32'(vc_read_en), 32'h1);
        @(negedge clk);
        credit_in = 4'b0010;
        #1;
        check("simul_credit0", 32'(u_dut.r_credit[0]), 32'd29);
        @(negedge clk);
        credit_in = 4'b0000;
        #1;
        check("inc_credit1", 32'(u_dut.r_credit[1]), 32'd30);
        check("inc_no_err", 32'(credit_err), 32'h0);

        // overflow on a full VC3
        do_reset();
        credit_in = 4'b1000;
        @(negedge clk);
        credit_in = 4'b0000;
        #1;
        check("ovf_err", 32'(credit_err), 32'h1);
        check("ovf_sat", 32'(u_dut.r_credit[3]), 32'd32);
        repeat (3) @(negedge clk);
        #1;
        check("ovf_sticky", 32'(credit_err), 32'h1);

        // reset in the middle of a stream
        for (int k = 0; k < 4; k++) push(1, 32'hBEEF0000 | 32'(k));
        @(negedge clk);
        @(negedge clk); #1;
        check("mid_lv", 32'(link_valid), 32'h1);
        check("mid_data", link_data, 32'hBEEF0000);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_lv", 32'(link_valid), 32'h0);
        check("mid_rst_err", 32'(credit_err), 32'h0);
        check("mid_rst_rd", 32'(vc_read_en), 32'h0);
        check("mid_rst_credit", 32'(u_dut.r_credit[1]), 32'd32);
        @(negedge clk);
        reset = 1'b0;

        // credit stall on the two-credit instance
        @(negedge clk);
        vc_empty2 = 4'b1101;
        #1;
        check("stall_rd0", 32'(vc_read_en2), 32'h2);
        @(negedge clk); #1;
        check("stall_rd1", 32'(vc_read_en2), 32'h2);
        @(negedge clk); #1;
        check("stall_rd2", 32'(vc_read_en2), 32'h0);
        check("stall_lv2", 32'(link_valid2), 32'h1);
        check("stall_vc2", 32'(link_vc2), 32'h1);
        check("stall_data2", link_data2, 32'h5A5A0001);
        @(negedge clk);
        credit_in2 = 4'b0010;
        #1;
        check("stall_credit_zero", 32'(u_dut2.r_credit[1]), 32'h0);
        check("stall_rd_pulse", 32'(vc_read_en2), 32'h0);
        @(negedge clk);
        credit_in2 = 4'b0000;
        #1;
        check("stall_rd_after", 32'(vc_read_en2), 32'h2);
        @(negedge clk); #1;
        check("stall_rd_again", 32'(vc_read_en2), 32'h0);
        check("stall_err", 32'(credit_err2), 32'h0);
        vc_empty2 = 4'b1111;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_link_scheduler.md
Name: vc_link_scheduler

Overview:
- Shares one output link among NUM_VC vc_buffer instances at one flit per cycle, using credit-based flow control towards the downstream router.
- Each cycle, a round-robin arbiter picks one VC that holds a flit and has a downstream credit. The block pops that VC's buffer, registers the flit and sends it on the link tagged with its VC id.
- It sits between the input VC buffers and the link/crossbar output port.

Parameters:
- NUM_VC, 4, number of VC buffers served (at least 2).
- VC_W, 2, width of the VC id; must be at least clog2(NUM_VC).
- DSIZE, 32, flit width; matches the vc_buffer DSIZE.
- CREDITS, 32, downstream buffer depth per VC; this is the initial credit count.
- CW, 6, credit counter width; must hold the value CREDITS.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- vc_empty  in  NUM_VC  empty flag from each vc_buffer.
- vc_data_out  in  NUM_VC*DSIZE  data_out of each vc_buffer, flattened; VC i occupies bits [i*DSIZE +: DSIZE].
- vc_read_en  out  NUM_VC  one-hot pop strobe to the vc_buffers; combinational.
- credit_in  in  NUM_VC  pulse from downstream returning one credit per VC.
- link_valid  out  1  registered; a flit is on the link this cycle.
- link_vc  out  VC_W  registered VC id of the link flit.
- link_data  out  DSIZE  registered flit.
- credit_err  out  1  sticky flag: a credit was returned while that VC was already full.
- busy  out  1  registered; any VC has a flit or a transfer is in flight.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - link_valid=0, link_vc=0, link_data=0.
  - credit_err=0, busy=0.
  - all credit counters = CREDITS; rr_ptr=0; pipeline valid bits = 0.
  - vc_read_en=0 while reset is high.
- Eligibility: VC i is eligible iff vc_empty[i]==0 and credit[i]!=0.
- Arbitration is combinational, cycle T:
  - Scan from rr_ptr upward, wrapping from NUM_VC-1 to 0. The first eligible VC is granted.
  - vc_read_en = onehot(grant). It is all-zero when no VC is eligible.
  - At most one bit is high in any cycle.
- End of cycle T, on a grant to VC g:
  - rr_ptr <= (g==NUM_VC-1) ? 0 : g+1.
  - credit[g] decrements.
  - s1_valid<=1 and s1_vc<=g; otherwise s1_valid<=0.
  - rr_ptr is unchanged when there is no grant.
- vc_buffer updates data_out at the edge that ends cycle T.
- Cycle T+1:
  - Sample vc_data_out slice s1_vc.
  - At the end of T+1, link_data<=slice, link_vc<=s1_vc, link_valid<=s1_valid.
- Latency: read_en in cycle T gives link_valid in cycle T+2. Throughput is one flit per cycle, back-to-back, including repeated grants to the same VC.
- Credit update per VC each edge: next = credit - dec + inc.
  - dec = granted this cycle; inc = credit_in[i].
  - Both in the same cycle leave the count unchanged.
- Credit overflow: credit_in[i] arrives with credit[i]==CREDITS and no decrement that cycle.
  - Counter saturates at CREDITS.
  - credit_err<=1 and stays high until reset.
- A VC with credit 0 is skipped by the arbiter. It becomes eligible in the cycle after its credit_in edge.
- vc_empty is trusted as presented. Because read_en is combinational from the current empty flag, a single-entry buffer is never double-popped.
- busy <= (|~vc_empty) | s1_valid | link_valid.
- Reset asserted mid-transfer: in-flight flits in s1 and on the link are discarded and credits return to CREDITS. The downstream side is reset in the same domain.

Test Plan:
- Post-reset idle: vc_empty=4'b1111 → vc_read_en=0, link_valid=0, busy=0, credit_err=0.
- Single flit:
  - Stimulus: VC2 holds 32'h0101A5A5; VC2 empty falls in cycle T.
  - Response: vc_read_en=4'b0100 in T; in T+2 link_valid=1, link_vc=2, link_data=32'h0101A5A5; VC2 credit=31.
- Round robin:
  - Stimulus: VC0..VC3 each hold 3 flits.
  - Response: grants 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; 12 contiguous link_valid cycles; rr_ptr ends at 0.
- Credit stall:
  - Stimulus: CREDITS=2; VC1 holds 4 flits; no credit_in.
  - Response: two pops, then vc_read_en=0. One credit_in[1] pulse gives exactly one further pop, granted in the cycle after the pulse.
- Simultaneous credit and grant:
  - Stimulus: credit_in[0] in the same cycle as a VC0 grant.
  - Response: credit[0] unchanged.
- Overflow:
  - Stimulus: credit_in[3] with credit[3]=CREDITS.
  - Response: credit_err=1 next cycle and stays 1. Mid-stream reset then clears link_valid and credit_err immediately (asynchronously).
